// File: rtl/sdf_pkg.sv
// Shared types and constant helpers for the radix-2^2 SDF FFT sequencer.
package sdf_pkg;

    localparam int unsigned LOG2N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sdf_state_e;

    function automatic logic [1:0] bitrev2(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    // Reverse the low w bits of x (w <= 10); upper bits come back zero.
    function automatic logic [9:0] bitrev(input logic [9:0] x, input int unsigned w);
        logic [9:0] r;
        logic [9:0] t;
        r = '0;
        t = x;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i < w) begin
                r = {r[8:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned stage_delay(input int unsigned log2n, input int unsigned k);
        return 32'd1 << (log2n - 1 - k);
    endfunction

    function automatic int unsigned cum_delay(input int unsigned log2n, input int unsigned k);
        int unsigned s;
        s = 0;
        for (int unsigned j = 0; j < k; j++) s += stage_delay(log2n, j);
        return s;
    endfunction

endpackage

// File: rtl/sdf_stage_ctl.sv
// Per-stage butterfly select and -j select decoded from the shared sample counter.
module sdf_stage_ctl
    import sdf_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEF,
    parameter int unsigned K     = 0
) (
    input  logic [LOG2N-1:0] cnt_i,
    output logic             sel_c_o,
    output logic             jmul_c_o
);

    localparam logic [LOG2N-1:0] D_K = LOG2N'(cum_delay(LOG2N, K));

    // Two bits of the stage-local count: [0] = half-frame phase, [1] = the bit above it.
    logic [1:0] c_hi;

    assign c_hi     = 2'((cnt_i - D_K) >> (LOG2N - 1 - K));
    assign sel_c_o  = c_hi[0];
    assign jmul_c_o = c_hi[1] & c_hi[0];

endmodule

// File: rtl/sdf_fft_seq.sv
// Frame sequencer for the radix-2^2 SDF FFT: datapath controls, flush, output markers.
// Define SDF_SEQ_BITREV_EN to report o_idx as the bit-reversed (true frequency) bin.
module sdf_fft_seq
    import sdf_pkg::*;
#(
    parameter int unsigned LOG2N   = LOG2N_DEF,
    parameter int unsigned N_STAGE = LOG2N,
    parameter int unsigned LAT     = (1 << LOG2N) - 1
) (
    input  logic                                  clk,
    input  logic                                  i_reset_n,
    input  logic                                  i_valid,
    input  logic                                  i_last,
    output logic                                  o_en,
    output logic                                  o_zero_in,
    output logic [LOG2N-1:0]                      o_bf_sel,
    output logic [LOG2N/2-1:0]                    o_jmul,
    output logic [((LOG2N > 2) ? LOG2N-2 : 1)-1:0] o_tw_addr,
    output logic                                  o_valid,
    output logic                                  o_sof,
    output logic                                  o_eof,
    output logic [LOG2N-1:0]                      o_idx,
    output logic                                  o_busy
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned JW   = LOG2N / 2;
    localparam int unsigned TW_W = (LOG2N > 2) ? LOG2N - 2 : 1;
    localparam int unsigned FW   = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAT_C = LOG2N'(LAT);
    localparam logic [LOG2N-1:0] D_TW  = LOG2N'(cum_delay(LOG2N, 2));

    // Async assert, clk-synchronous release.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    sdf_state_e        state_q, state_d;
    logic [LOG2N-1:0]  cnt_q, cnt_d, fill_q, fill_d;
    logic [FW-1:0]     flush_q, flush_d;
    logic              en_q, en_d, zero_q, zero_d, valid_q, valid_d;
    logic              sof_q, sof_d, eof_q, eof_d, busy_q, busy_d;
    logic [LOG2N-1:0]  sel_q, sel_d, idx_q, idx_d;
    logic [JW-1:0]     jmul_q, jmul_d;
    logic [TW_W-1:0]   tw_q, tw_d;

    logic              active_c;
    logic [LOG2N-1:0]  sel_c, jmul_all_c, nat_c, idx_c;
    logic [JW-1:0]     jmul_c;
    logic [TW_W-1:0]   tw_c;
    logic              jmul_unused_c;

    for (genvar k = 0; k < N_STAGE; k++) begin : g_stage
        sdf_stage_ctl #(.LOG2N(LOG2N), .K(k)) u_ctl (
            .cnt_i   (cnt_q),
            .sel_c_o (sel_c[k]),
            .jmul_c_o(jmul_all_c[k])
        );
    end

    // Only BF-II (odd) stages own a -j rotator.
    always_comb begin
        jmul_c        = '0;
        jmul_unused_c = 1'b0;
        for (int p = 0; p < JW; p++) begin
            jmul_c[p]     = jmul_all_c[2*p+1];
            jmul_unused_c = jmul_unused_c ^ jmul_all_c[2*p];
        end
    end

    if (LOG2N > 2) begin : g_tw
        logic [LOG2N-1:0] c_tw;
        assign c_tw = cnt_q - D_TW;
        assign tw_c = TW_W'(bitrev2(c_tw[LOG2N-1 -: 2])) * c_tw[LOG2N-3:0];
    end else begin : g_no_tw
        assign tw_c = '0;
    end

    assign nat_c = cnt_q - LAT_C;
`ifdef SDF_SEQ_BITREV_EN
    assign idx_c = LOG2N'(bitrev(10'(nat_c), LOG2N));
`else
    assign idx_c = nat_c;
`endif

    assign active_c = i_valid || (state_q == FLUSH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        flush_d = flush_q;
        en_d    = 1'b0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        zero_d  = zero_q;
        sel_d   = sel_q;
        jmul_d  = jmul_q;
        tw_d    = tw_q;
        idx_d   = idx_q;
        if (active_c) begin
            cnt_d   = cnt_q + LOG2N'(1);
            fill_d  = (fill_q == LAT_C) ? fill_q : fill_q + LOG2N'(1);
            en_d    = 1'b1;
            zero_d  = (state_q == FLUSH);
            sel_d   = sel_c;
            jmul_d  = jmul_c;
            tw_d    = tw_c;
            valid_d = (fill_q == LAT_C);
            idx_d   = valid_d ? idx_c : '0;
            sof_d   = valid_d && (nat_c == '0);
            eof_d   = valid_d && (nat_c == '1);
            unique case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if ((fill_q + LOG2N'(1)) == LAT_C) state_d = RUN;
                RUN:     state_d = RUN;
                FLUSH: begin
                    flush_d = flush_q - FW'(1);
                    if (flush_q == FW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fill_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Zero-pad to the frame end, then drain LAT cycles.
            if (state_q != FLUSH && i_last) begin
                state_d = FLUSH;
                flush_d = FW'(N - 1 + LAT) - FW'(cnt_q);
            end
        end else if (state_q == IDLE) begin
            zero_d = 1'b0;
            sel_d  = '0;
            jmul_d = '0;
            tw_d   = '0;
            idx_d  = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            flush_q <= '0;
            en_q    <= 1'b0;
            zero_q  <= 1'b0;
            sel_q   <= '0;
            jmul_q  <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            flush_q <= flush_d;
            en_q    <= en_d;
            zero_q  <= zero_d;
            sel_q   <= sel_d;
            jmul_q  <= jmul_d;
            tw_q    <= tw_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_en      = en_q;
    assign o_zero_in = zero_q;
    assign o_bf_sel  = sel_q;
    assign o_jmul    = jmul_q;
    assign o_tw_addr = tw_q;
    assign o_valid   = valid_q;
    assign o_sof     = sof_q;
    assign o_eof     = eof_q;
    assign o_idx     = idx_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_sdf_fft_seq.sv
// Scoreboard bench for sdf_fft_seq (LOG2N = 4); honours SDF_SEQ_BITREV_EN for o_idx.
module tb_sdf_fft_seq;

    localparam int L   = 4;
    localparam int N   = 16;
    localparam int LAT = 15;

    logic clk = 1'b0;
    logic i_reset_n, i_valid, i_last;
    logic o_en, o_zero_in, o_valid, o_sof, o_eof, o_busy;
    logic [3:0] o_bf_sel, o_idx;
    logic [1:0] o_jmul, o_tw_addr;

    always #5 clk = ~clk;

    sdf_fft_seq dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_last(i_last),
        .o_en(o_en), .o_zero_in(o_zero_in), .o_bf_sel(o_bf_sel), .o_jmul(o_jmul),
        .o_tw_addr(o_tw_addr), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
        .o_idx(o_idx), .o_busy(o_busy)
    );

    typedef struct {
        int en, zero, sel, jmul, tw, valid, sof, eof, idx, busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_err = 0;
    int   n_val = 0, n_sof = 0, n_eof = 0, n_zero = 0;

    // Reference state: session open, flushing, active count, end count, held controls.
    bit   m_sess = 0, m_flush = 0;
    int   m_n = 0, m_end = 0;
    exp_t m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dk(input int k);
        int s = 0;
        for (int j = 0; j < k; j++) s += N >> (j + 1);
        return s;
    endfunction

    function automatic int brev(input int x, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) if (((x >> i) & 1) != 0) r |= 1 << (w - 1 - i);
        return r;
    endfunction

    function automatic exp_t model_active(input int n, input int zero);
        exp_t e;
        int c, ck, ct, hi, lo, br, nat;
        e = '{default:0};
        c = n % N;
        e.en = 1;
        e.zero = zero;
        for (int k = 0; k < L; k++) begin
            ck = (c - dk(k) + N) % N;
            e.sel |= ((ck >> (L - 1 - k)) & 1) << k;
            if (k % 2 == 1) e.jmul |= ((ck >> (L - k)) & (ck >> (L - 1 - k)) & 1) << (k / 2);
        end
        ct = (c - dk(2) + N) % N;
        hi = ct >> (L - 2);
        lo = ct & (N / 4 - 1);
        br = ((hi & 1) << 1) | ((hi >> 1) & 1);
        e.tw = (br * lo) % (N / 4);
        if (n >= LAT) begin
            nat = (n - LAT) % N;
            e.valid = 1;
`ifdef SDF_SEQ_BITREV_EN
            e.idx = brev(nat, L);
`else
            e.idx = nat;
`endif
            e.sof = (nat == 0) ? 1 : 0;
            e.eof = (nat == N - 1) ? 1 : 0;
        end
        return e;
    endfunction

    // One clock: drive inputs at negedge, push expectation, return just after the edge.
    task automatic drive(input logic v, input logic l);
        exp_t e;
        bit   fl0;
        @(negedge clk);
        i_valid = v;
        i_last  = l;
        fl0 = m_flush;
        if (fl0 || v) begin
            if (!m_sess) begin
                m_sess = 1;
                m_n = 0;
            end
            e = model_active(m_n, int'(fl0));
            if (!fl0 && l) begin
                m_flush = 1;
                m_end = m_n + 1 + (N - 1 - m_n % N) + LAT;
            end
            m_n++;
            e.busy = 1;
            if (m_flush && m_n == m_end) begin
                m_sess = 0;
                m_flush = 0;
                e.busy = 0;
            end
            m_prev = e;
        end else if (m_sess) begin
            e = m_prev;
            e.en = 0; e.valid = 0; e.sof = 0; e.eof = 0; e.busy = 1;
            m_prev = e;
        end else begin
            e = '{default:0};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("en",    32'(o_en),      32'(e.en));
                check("zero",  32'(o_zero_in), 32'(e.zero));
                check("sel",   32'(o_bf_sel),  32'(e.sel));
                check("jmul",  32'(o_jmul),    32'(e.jmul));
                check("tw",    32'(o_tw_addr), 32'(e.tw));
                check("valid", 32'(o_valid),   32'(e.valid));
                check("sof",   32'(o_sof),     32'(e.sof));
                check("eof",   32'(o_eof),     32'(e.eof));
                check("idx",   32'(o_idx),     32'(e.idx));
                check("busy",  32'(o_busy),    32'(e.busy));
                n_val  += int'(o_valid);
                n_sof  += int'(o_sof);
                n_eof  += int'(o_eof);
                n_zero += int'(o_zero_in);
            end
        end
    end

    task automatic clr();
        n_val = 0; n_sof = 0; n_eof = 0; n_zero = 0;
    endtask

    // Drain the flush (bounded); upstream noise on i_valid must be ignored.
    task automatic run_flush(input string tag);
        for (int i = 0; i < 200 && m_sess; i++) drive(1'($urandom_range(0, 1)), 1'b0);
        check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    endtask

    task automatic tally(input string tag, input int v, input int s, input int e, input int z);
        check({tag, "_valid_cnt"}, 32'(n_val),  32'(v));
        check({tag, "_sof_cnt"},   32'(n_sof),  32'(s));
        check({tag, "_eof_cnt"},   32'(n_eof),  32'(e));
        check({tag, "_zero_cnt"},  32'(n_zero), 32'(z));
    endtask

    function automatic logic [31:0] all_out();
        return 32'({o_en, o_zero_in, o_bf_sel, o_jmul, o_tw_addr, o_valid, o_sof, o_eof, o_idx, o_busy});
    endfunction

    initial begin : stim
        int k;
        logic v;
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_last    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out(), 32'd0);
        i_reset_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0);

        // Two back-to-back frames, last on sample 31.
        clr();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'(i == 31));
            if (i == 14) check("t1_no_valid_fill", 32'(n_val), 32'd0);
            if (i == 15) check("t1_first_valid", 32'(n_val), 32'd1);
        end
        run_flush("t2");
        tally("t2", 32, 2, 2, 15);

        // Three-cycle gap at cnt = 5.
        clr();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                repeat (3) drive(1'b0, 1'b0);
                check("t3_en_gap", 32'(o_en), 32'd0);
            end
            drive(1'b1, 1'(i == 15));
        end
        run_flush("t3");
        tally("t3", 16, 1, 1, 15);

        // Early last at cnt = 9: 6 pad + 15 drain.
        clr();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'(i == 9));
        run_flush("t4");
        tally("t4", 16, 1, 1, 21);

        // Reset mid-RUN at cnt = 7, then a clean frame.
        clr();
        for (int i = 0; i < 23; i++) drive(1'b1, 1'b0);
        #3;
        i_reset_n = 1'b0;
        #1;
        check("t5_async_reset", all_out(), 32'd0);
        m_sess = 0;
        m_flush = 0;
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0);
        clr();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'(i == 15));
        run_flush("t5");
        tally("t5", 16, 1, 1, 15);

        // Single-sample frame (impulse-style): full bin sequence with o_idx mapping.
        clr();
        drive(1'b1, 1'b1);
        run_flush("t6");
        tally("t6", 16, 1, 1, 30);

        // Random gaps, 40 samples: last at cnt = 7 -> 8 pad + 15 drain.
        clr();
        k = 0;
        for (int t = 0; t < 400 && k < 40; t++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) k++;
            drive(v, v && (k == 40));
        end
        run_flush("t7");
        tally("t7", 48, 3, 3, 23);

        drive(1'b0, 1'b0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
